reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N, default 4: data width of each bank register.
REQ-002 Parameter AW, default 2: address width; bank holds NREG = 2**AW registers.
REQ-003 Port clock, input, 1: positive-edge clock; the only clock.
REQ-004 Port R, input, 1: reset, synchronous, active-high.
REQ-005 Ports req_a / req_b, input, 1 each: write request from requester A / B, level, held until granted.
REQ-006 Ports addr_a / addr_b, input, AW each: target register index for A / B.
REQ-007 Ports data_a / data_b, input, N each: write data for A / B.
REQ-008 Ports gnt_a / gnt_b, output, 1 each: registered one-cycle grant pulse.
REQ-009 Port L, output, NREG: registered one-hot load enables, one per bank register.
REQ-010 Port D, output, N: registered write data shared by all bank registers.
REQ-011 Port busy, output, 1: high while the FSM is in WRITE.

Function
REQ-012 FSM SHALL have exactly two states: IDLE and WRITE.
REQ-013 Each rising edge SHALL sample req_a/req_b; a winner exists if either is high.
REQ-014 Winner exists -> next state WRITE; none -> next state IDLE; this holds from either state.
REQ-015 Single requester SHALL win unconditionally.
REQ-016 Both requesting: winner SHALL be the requester not granted most recently (round-robin); after reset, A wins first.
REQ-017 Round-robin pointer SHALL update only on a grant and SHALL hold in IDLE.
REQ-018 In WRITE, exactly one of gnt_a/gnt_b SHALL be 1, L SHALL equal onehot(winner addr), D SHALL equal winner data; all values are captured at the edge entering WRITE.
REQ-019 In IDLE: gnt_a=gnt_b=0, L=0; D SHALL hold its last value.
REQ-020 Latency: request high before edge k -> grant, L and D valid during cycle k..k+1; the bank loads at edge k+1.
REQ-021 Requester SHALL deassert or replace req/addr/data by the edge ending its grant cycle; req high at that edge is a new request.
REQ-022 Back-to-back: both held continuously SHALL alternate A,B,A,B with no idle cycle; one held continuously SHALL be granted every cycle.
REQ-023 Same addr from A and B: only the winner writes that cycle; the loser is served next cycle, and its data is the final register content.
REQ-024 L SHALL never have more than one bit set; gnt_a and gnt_b SHALL never both be 1.
REQ-025 busy SHALL equal (state == WRITE).

Reset
REQ-026 R high at a rising edge SHALL force state=IDLE, gnt_a=gnt_b=0, L=0, D=0, busy=0, pointer=favour A; this overrides any request.
REQ-027 R asserted during WRITE SHALL cancel the write: L=0 from the next cycle, and no grant is reissued for the cancelled request.
REQ-028 First grant possible at the first edge after R deasserts.

Structure
REQ-029 Shared package SHALL hold the state typedef (IDLE, WRITE) and the defaults for N and AW.
REQ-030 Round-robin pick logic SHALL be one combinational sub-module, rr_pick2 (inputs req_a, req_b, last_was_a; output pick_a, valid).
REQ-031 All outputs SHALL come directly from flops; there SHALL be no combinational input-to-output path.

Verification
REQ-032 R=1 for 2 cycles with req_a=1 -> gnt=0, L=0, D=0, busy=0 throughout.
REQ-033 Only req_a=1, addr_a=2, data_a=4'hA for 1 cycle -> next cycle gnt_a=1, L=4'b0100, D=4'hA; following cycle IDLE, L=0.
REQ-034 req_a, req_b both held for 4 cycles after reset -> grants A,B,A,B; busy high for 4 cycles.
REQ-035 A: addr=1, data=4'h3; B: addr=1, data=4'hC, same cycle -> A granted first, then B; a bank model shows reg1=4'hC.
REQ-036 R pulsed during a WRITE granting B -> L=0 next cycle; with req_a/req_b then high, A granted first.
REQ-037 Random requests for 1000 cycles -> scoreboard bank contents match the model; L is one-hot or zero, and no requester waits more than 1 cycle while requesting.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter.
//   state_t    : arbiter FSM state (IDLE, WRITE)
//   N_DEFAULT  : default data width of each bank register
//   AW_DEFAULT : default bank address width (bank holds 2**AW registers)
package reg_write_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam int N_DEFAULT  = 4;
    localparam int AW_DEFAULT = 2;

endpackage

// File: rtl/reg_write_arbiter_rr_pick2.sv
// Two-way round-robin pick, purely combinational.
//   req_a, req_b : level requests from requester A / B
//   last_was_a   : 1 when A was the most recently granted requester
//   pick_a       : 1 selects A, 0 selects B (meaningful only when valid)
//   valid        : at least one requester is asking
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_was_a,
    output logic pick_a,
    output logic valid
);

    assign valid = req_a | req_b;

    // A wins when it is alone, or when both ask and B was served last.
    assign pick_a = req_a & (~req_b | ~last_was_a);

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates single-register writes from two requesters into a shared bank.
//   clock          : positive-edge clock
//   R              : synchronous active-high reset
//   req_a / req_b  : level write requests, held until granted
//   addr_a/addr_b  : target register index
//   data_a/data_b  : write data
//   gnt_a / gnt_b  : one-cycle grant pulse, registered
//   L              : one-hot bank load enables, registered (zero in IDLE)
//   D              : write data shared by all bank registers, registered
//   busy           : high while the FSM is in WRITE
//
// Handshake: a requester holds req/addr/data until it sees its grant; the
// grant cycle is the write cycle. By the edge that ends the grant cycle the
// requester drops req or presents the next request -- req still high at that
// edge is taken as a fresh request. The bank loads at that same edge.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic                 clock,
    input  logic                 R,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic [AW-1:0]        addr_a,
    input  logic [AW-1:0]        addr_b,
    input  logic [N-1:0]         data_a,
    input  logic [N-1:0]         data_b,
    output logic                 gnt_a,
    output logic                 gnt_b,
    output logic [(2**AW)-1:0]   L,
    output logic [N-1:0]         D,
    output logic                 busy
);

    localparam int NREG = 2**AW;
    localparam logic [NREG-1:0] ONE_HOT_BASE = NREG'(1);

    state_t state;
    state_t state_next;
    logic   last_was_a;
    logic   pick_a;
    logic   valid;

    rr_pick2 u_pick (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_was_a (last_was_a),
        .pick_a     (pick_a),
        .valid      (valid)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state depends only on whether anyone is asking, from either state.
    always_comb begin
        state_next = IDLE;
        if (valid) begin
            state_next = WRITE;
        end
    end

    // Output flops: everything the WRITE cycle presents is captured at the
    // edge entering WRITE. D keeps its last value through IDLE.
    always_ff @(posedge clock) begin
        if (R) begin
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            L          <= '0;
            D          <= '0;
            last_was_a <= 1'b0;   // favour A after reset
        end else begin
            gnt_a <= valid & pick_a;
            gnt_b <= valid & ~pick_a;
            L     <= '0;
            if (valid) begin
                last_was_a <= pick_a;
                if (pick_a) begin
                    L <= ONE_HOT_BASE << addr_a;
                    D <= data_a;
                end else begin
                    L <= ONE_HOT_BASE << addr_b;
                    D <= data_b;
                end
            end
        end
    end

    assign busy = (state == WRITE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios with literal expectations,
// a behavioural model feeding an expected-output queue checked every cycle,
// and a bank scoreboard comparing what the DUT writes with what it should.
module tb_reg_write_arbiter;

    localparam int W = 11;   // {gnt_a, gnt_b, L[3:0], D[3:0], busy}

    logic       clock;
    logic       R;
    logic       req_a;
    logic       req_b;
    logic [1:0] addr_a;
    logic [1:0] addr_b;
    logic [3:0] data_a;
    logic [3:0] data_b;
    logic       gnt_a;
    logic       gnt_b;
    logic [3:0] L;
    logic [3:0] D;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    // Model state
    logic       m_last_a = 1'b0;
    logic [3:0] m_d      = 4'h0;
    logic       m_wr     = 1'b0;
    logic [1:0] m_addr   = 2'd0;
    logic [3:0] m_data   = 4'h0;
    logic       m_a_wins;
    logic [W-1:0] m_e;
    logic [3:0] exp_bank[4];
    logic [3:0] dut_bank[4];
    logic       req_a_s = 1'b0;
    logic       req_b_s = 1'b0;
    int         wait_a = 0;
    int         wait_b = 0;
    logic [W-1:0] c_e;

    reg_write_arbiter dut (
        .clock  (clock),
        .R      (R),
        .req_a  (req_a),
        .req_b  (req_b),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .data_a (data_a),
        .data_b (data_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .L      (L),
        .D      (D),
        .busy   (busy)
    );

    // Clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            exp_bank[i] = 4'h0;
            dut_bank[i] = 4'h0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string name, input logic ga, input logic gb,
                              input logic [3:0] l, input logic [3:0] d, input logic bz);
        check({name, ".gnt_a"}, 32'(gnt_a), 32'(ga));
        check({name, ".gnt_b"}, 32'(gnt_b), 32'(gb));
        check({name, ".L"},     32'(L),     32'(l));
        check({name, ".D"},     32'(D),     32'(d));
        check({name, ".busy"},  32'(busy),  32'(bz));
    endtask

    // Inputs change 1 time unit after the falling edge, after the compare.
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic drive(input logic ra, input logic [1:0] aa, input logic [3:0] da,
                         input logic rb, input logic [1:0] ab, input logic [3:0] db);
        req_a  = ra;
        addr_a = aa;
        data_a = da;
        req_b  = rb;
        addr_b = ab;
        data_b = db;
    endtask

    // Behavioural model: at each rising edge apply the bank write of the
    // cycle just ending, then decide from the sampled requests what the next
    // cycle must show.
    always @(posedge clock) begin
        if (m_wr) exp_bank[m_addr] = m_data;
        for (int i = 0; i < 4; i++) begin
            if (L[i] === 1'b1) dut_bank[i] = D;
        end

        if (R) begin
            m_last_a = 1'b0;
            m_d      = 4'h0;
            m_wr     = 1'b0;
            m_e      = '0;
        end else if (req_a || req_b) begin
            m_a_wins = req_a && !(req_b && m_last_a);
            m_addr   = m_a_wins ? addr_a : addr_b;
            m_data   = m_a_wins ? data_a : data_b;
            m_wr     = 1'b1;
            m_last_a = m_a_wins;
            m_d      = m_data;
            m_e      = {m_a_wins, !m_a_wins, 4'(1 << m_addr), m_d, 1'b1};
        end else begin
            m_wr = 1'b0;
            m_e  = {2'b00, 4'b0000, m_d, 1'b0};
        end
        exp_q.push_back(m_e);
        req_a_s = req_a & ~R;
        req_b_s = req_b & ~R;
    end

    // Compare process: every cycle, once the model has an expectation.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            c_e = exp_q.pop_front();
            check("cyc.gnt_a", 32'(gnt_a), 32'(c_e[10]));
            check("cyc.gnt_b", 32'(gnt_b), 32'(c_e[9]));
            check("cyc.L",     32'(L),     32'(c_e[8:5]));
            check("cyc.D",     32'(D),     32'(c_e[4:1]));
            check("cyc.busy",  32'(busy),  32'(c_e[0]));
            check("cyc.L_onehot_or_zero", 32'($countones(L) <= 1), 32'd1);
            check("cyc.gnt_exclusive", 32'(gnt_a & gnt_b), 32'd0);
            if (req_a_s && !gnt_a) wait_a++; else wait_a = 0;
            if (req_b_s && !gnt_b) wait_b++; else wait_b = 0;
            check("cyc.wait_a_le_1", 32'(wait_a <= 1), 32'd1);
            check("cyc.wait_b_le_1", 32'(wait_b <= 1), 32'd1);
        end
    end

    // Directed scenarios
    initial begin
        R = 1'b1;
        drive(1'b1, 2'd3, 4'h5, 1'b0, 2'd0, 4'h0);

        // Reset held two cycles with req_a high
        step();
        expect_out("reset1", 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0);
        step();
        expect_out("reset2", 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0);

        // Single request from A, first edge after reset release
        R = 1'b0;
        drive(1'b1, 2'd2, 4'hA, 1'b0, 2'd0, 4'h0);
        step();
        expect_out("single_a", 1'b1, 1'b0, 4'b0100, 4'hA, 1'b1);
        drive(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);
        step();
        expect_out("single_a_idle", 1'b0, 1'b0, 4'b0000, 4'hA, 1'b0);

        // Both held after a reset: A,B,A,B with busy every cycle
        R = 1'b1;
        step();
        R = 1'b0;
        drive(1'b1, 2'd0, 4'h1, 1'b1, 2'd3, 4'h2);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i % 2 == 0)
                expect_out("alt_a", 1'b1, 1'b0, 4'b0001, 4'h1, 1'b1);
            else
                expect_out("alt_b", 1'b0, 1'b1, 4'b1000, 4'h2, 1'b1);
        end
        drive(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);
        step();
        expect_out("alt_idle", 1'b0, 1'b0, 4'b0000, 4'h2, 1'b0);

        // Same address from both: A first, then B; B's data remains
        drive(1'b1, 2'd1, 4'h3, 1'b1, 2'd1, 4'hC);
        step();
        expect_out("same_addr_a", 1'b1, 1'b0, 4'b0010, 4'h3, 1'b1);
        drive(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 4'hC);
        step();
        expect_out("same_addr_b", 1'b0, 1'b1, 4'b0010, 4'hC, 1'b1);
        drive(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);
        step();
        check("same_addr_bank1", 32'(dut_bank[1]), 32'h0000000C);

        // Reset during a WRITE granting B cancels it; A then wins first
        drive(1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 4'h7);
        step();
        expect_out("pre_cancel_b", 1'b0, 1'b1, 4'b0100, 4'h7, 1'b1);
        R = 1'b1;
        drive(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);
        step();
        expect_out("cancel", 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0);
        R = 1'b0;
        drive(1'b1, 2'd3, 4'h9, 1'b1, 2'd0, 4'h6);
        step();
        expect_out("post_cancel_a", 1'b1, 1'b0, 4'b1000, 4'h9, 1'b1);
        drive(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);
        step();

        // Random traffic
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            step();
        end
        drive(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);
        step();
        step();

        for (int i = 0; i < 4; i++) begin
            check("bank_final", 32'(dut_bank[i]), 32'(exp_bank[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
